// File: rtl/serial_uart_tx.sv
// serial_uart_tx: FIFO-buffered 8N1 UART transmitter for the serial console.
// Bytes are sent LSB first with no idle gap between queued frames.
module serial_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       wren_in,
  output logic       ready_out,
  output logic       tx_out,
  output logic       busy_out,
  output logic       overflow_out
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BLAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nxt;
  logic [7:0] mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] rptr, wptr;
  logic [FIFO_AW:0] count;
  logic [BW-1:0] bcnt, bcnt_nxt;
  logic [2:0] bidx, bidx_nxt;
  logic [7:0] shift, shift_nxt;
  logic tx_nxt, bterm, pop, push;
  // fullness uses the pre-edge count, so a same-edge pop never rescues a push
  assign push = wren_in && count != DEPTH;
  assign bterm = bcnt == BLAST;
  assign ready_out = count != DEPTH;
  assign busy_out = state != IDLE || count != '0;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = count != '0 ? START : IDLE;
      START: state_nxt = bterm ? DATA : START;
      DATA:  state_nxt = bterm && bidx == 3'd7 ? STOP : DATA;
      STOP:  state_nxt = !bterm ? STOP : count != '0 ? START : IDLE;
    endcase
    pop = count != '0 && (state == IDLE || (state == STOP && bterm));
    bcnt_nxt = (state == IDLE || bterm) ? '0 : bcnt + BW'(1);
    bidx_nxt = state == DATA ? bidx + 3'(bterm) : '0;
    shift_nxt = pop ? mem[rptr] : (state == DATA && bterm) ? shift >> 1 : shift;
    tx_nxt = state_nxt == START ? 1'b0 : state_nxt == DATA ? shift_nxt[0] : 1'b1;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rptr <= '0;
      wptr <= '0;
      count <= '0;
      bcnt <= '0;
      bidx <= '0;
      shift <= '0;
      tx_out <= 1'b1;
      overflow_out <= 1'b0;
    end else begin
      state <= state_nxt;
      bcnt <= bcnt_nxt;
      bidx <= bidx_nxt;
      shift <= shift_nxt;
      tx_out <= tx_nxt;
      if (push) wptr <= wptr + FIFO_AW'(1);
      if (pop) rptr <= rptr + FIFO_AW'(1);
      count <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
      if (wren_in && !push) overflow_out <= 1'b1;
    end
  end
  always_ff @(posedge clock) if (push) mem[wptr] <= data_in;
endmodule

// File: tb/tb_serial_uart_tx.sv
// tb_serial_uart_tx: random and directed pushes scored against a queue of
// expected bytes; a line monitor decodes 8N1 frames and checks bit timing.
module tb_serial_uart_tx;
  localparam int CPB = 4;
  logic clock = 0, reset = 0, wren_in = 0;
  logic [7:0] data_in = 0;
  logic ready_out, tx_out, busy_out, overflow_out;
  int n_checks = 0, n_pass = 0;
  logic [7:0] expq[$];
  int cyc = 0, frames = 0, prev_start = 0, last_start = 0, pos = 0;
  bit in_frame = 0, stable = 1;
  logic [9:0] bits;

  always #5 clock = ~clock;

  serial_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(3)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .wren_in(wren_in),
    .ready_out(ready_out), .tx_out(tx_out), .busy_out(busy_out),
    .overflow_out(overflow_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // line monitor: every cycle of a bit must hold the level seen at its first cycle
  always @(negedge clock) begin
    cyc++;
    if (!reset) in_frame = 0;
    else begin
      if (!in_frame && tx_out === 1'b0) begin
        in_frame = 1;
        pos = 0;
        stable = 1;
        prev_start = last_start;
        last_start = cyc;
      end
      if (in_frame) begin
        if (pos % CPB == 0) bits[pos / CPB] = tx_out;
        else if (tx_out !== bits[pos / CPB]) stable = 0;
        pos++;
        if (pos == 10 * CPB) begin
          in_frame = 0;
          frames++;
          check("bit_hold", 32'(stable), 1);
          check("frame_expected", 32'(expq.size() != 0), 1);
          if (expq.size() != 0) check("frame_bits", 32'(bits), 32'({1'b1, expq.pop_front(), 1'b0}));
        end
      end
    end
  end

  task automatic push(input logic [7:0] b, input bit accept);
    data_in = b;
    wren_in = 1;
    if (accept) expq.push_back(b);
    @(negedge clock);
    wren_in = 0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((expq.size() != 0 || busy_out || in_frame) && t < 3000) begin
      @(negedge clock);
      t++;
    end
    check(name, 32'(t < 3000), 1);
    @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int f0, lows, w;
    repeat (3) @(negedge clock);
    check("rst_tx", 32'(tx_out), 1);
    check("rst_ready", 32'(ready_out), 1);
    check("rst_busy", 32'(busy_out), 0);
    check("rst_ovf", 32'(overflow_out), 0);
    reset = 1;
    repeat (10) @(negedge clock);
    check("idle_tx", 32'(tx_out), 1);
    check("idle_busy", 32'(busy_out), 0);
    check("idle_frames", 32'(frames), 0);

    push(8'h55, 1);
    check("lat_edge_n", 32'(tx_out), 1);
    check("busy_after_push", 32'(busy_out), 1);
    @(negedge clock);
    check("lat_edge_n1", 32'(tx_out), 0);
    repeat (39) @(negedge clock);
    check("stop_busy", 32'(busy_out), 1);
    check("stop_tx", 32'(tx_out), 1);
    @(negedge clock);
    check("busy_drop", 32'(busy_out), 0);
    drain("drain_single");

    push(8'hA3, 1);
    push(8'h0F, 1);
    drain("drain_b2b");
    check("b2b_gap", 32'(last_start - prev_start), 10 * CPB);

    for (int i = 1; i <= 10; i++) begin
      push(8'(i), i <= 9);
      if (i == 8) check("ready_at_7", 32'(ready_out), 1);
      if (i == 9) begin
        check("ready_full", 32'(ready_out), 0);
        check("ovf_before_drop", 32'(overflow_out), 0);
      end
      if (i == 10) begin
        check("ovf_set", 32'(overflow_out), 1);
        check("ready_still_full", 32'(ready_out), 0);
      end
    end
    drain("drain_overflow");
    check("ready_after_drain", 32'(ready_out), 1);

    for (int i = 0; i < 12; i++) begin
      w = 0;
      while (!ready_out && w < 500) begin
        @(negedge clock);
        w++;
      end
      check("ready_wait", 32'(w < 500), 1);
      push(8'($urandom_range(255, 0)), 1);
      repeat ($urandom_range(6, 0)) @(negedge clock);
    end
    drain("drain_wrap");
    check("ovf_sticky", 32'(overflow_out), 1);

    push(8'h00, 1);
    push(8'($urandom_range(255, 0)), 1);
    push(8'($urandom_range(255, 0)), 1);
    repeat (6) @(negedge clock);
    check("pre_reset_data_low", 32'(tx_out), 0);
    #2;
    reset = 0;
    expq.delete();
    #1;
    check("midrst_tx", 32'(tx_out), 1);
    check("midrst_busy", 32'(busy_out), 0);
    check("midrst_ready", 32'(ready_out), 1);
    check("midrst_ovf", 32'(overflow_out), 0);
    repeat (3) @(negedge clock);
    reset = 1;
    f0 = frames;
    lows = 0;
    repeat (100) begin
      @(negedge clock);
      if (tx_out !== 1'b1) lows++;
    end
    check("post_rst_line_idle", 32'(lows), 0);
    check("post_rst_no_frames", 32'(frames - f0), 0);
    check("post_rst_busy", 32'(busy_out), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
